clip_record_play_core: RTL and testbench

- Recording/playback control core of the two-clip audio recorder.
- Combines three functions:
  - the record/play state machine (controller);
  - the shared block-RAM address counter (counter);
  - a PDM microphone deserializer.
- Drives two external 16-bit x 128K block RAMs, an external PWM serializer and an external duration timer.
- Sits between the synchronized button inputs and the memories, serializer and timer; also feeds clip numbers to the LED display block.

---
 rtl/clip_core_pkg.sv | 18 +
 rtl/pdm_deserializer.sv | 81 ++++++++
 rtl/clip_record_play_core.sv | 158 +++++++++++++++
 tb/tb_clip_record_play_core.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clip_core_pkg.sv
// Shared types and constants for the two-clip record/play core.
package clip_core_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    RECORD = 2'd2
  } state_t;

  localparam int ADDR_WIDTH = 17;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = 17'h1FFFF;

  // System cycles per PDM clock half-period.
  function automatic int half_period(input int sys_mhz, input int samp_mhz);
    return sys_mhz / (2 * samp_mhz);
  endfunction

endpackage

// File: rtl/pdm_deserializer.sv
// PDM microphone deserializer: clock divider, MSB-first shift register and
// bit counter producing one WORD_LENGTH-bit word per WORD_LENGTH PDM periods.
import clip_core_pkg::*;

module pdm_deserializer #(
  parameter int WORD_LENGTH = 16,
  parameter int HALF        = 5
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic                   pdm_data_i,
  output logic                   pdm_clk_o,
  output logic                   done_o,
  output logic [WORD_LENGTH-1:0] data_o
);

  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CNT_W = $clog2(WORD_LENGTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_LENGTH);

  logic [DIV_W-1:0]       div_q, div_d;
  logic                   pdm_clk_q, pdm_clk_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic                   done_q, done_d;

  // Samples are taken on the rising toggle; a full word is handed over on the
  // following falling toggle, so the word boundary lands on a PDM period edge.
  always_comb begin
    div_d     = div_q;
    pdm_clk_d = pdm_clk_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    if (!enable_i) begin
      div_d     = '0;
      pdm_clk_d = 1'b0;
      bit_cnt_d = '0;
    end else if (div_q == DIV_LAST) begin
      div_d     = '0;
      pdm_clk_d = ~pdm_clk_q;
      if (!pdm_clk_q) begin
        shift_d   = {shift_q[WORD_LENGTH-2:0], pdm_data_i};
        bit_cnt_d = bit_cnt_q + 1'b1;
      end else if (bit_cnt_q == CNT_FULL) begin
        data_d    = shift_q;
        done_d    = 1'b1;
        bit_cnt_d = '0;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      div_q     <= '0;
      pdm_clk_q <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      pdm_clk_q <= pdm_clk_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  assign pdm_clk_o = pdm_clk_q;
  assign done_o    = done_q;
  assign data_o    = data_q;

endmodule

// File: rtl/clip_record_play_core.sv
// Record/play controller for the two-clip recorder: command FSM, shared
// block-RAM address counter and the PDM microphone deserializer.
import clip_core_pkg::*;

module clip_record_play_core #(
  parameter int WORD_LENGTH        = 16,
  parameter int SYSTEM_FREQUENCY   = 100,
  parameter int SAMPLING_FREQUENCY = 10
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   play_command_i,
  input  logic                   record_command_i,
  input  logic                   play_clip_select_i,
  input  logic                   record_clip_select_i,
  input  logic                   timer_done_i,
  input  logic                   serializer_done_i,
  input  logic                   pdm_data_i,
  output logic                   pdm_clk_o,
  output logic                   playing_o,
  output logic                   recording_o,
  output logic [3:0]             play_clip_o,
  output logic [3:0]             record_clip_o,
  output logic                   timer_enable_o,
  output logic                   serializer_enable_o,
  output logic                   deserializer_done_o,
  output logic [WORD_LENGTH-1:0] deserializer_data_o,
  output logic                   memory_rw_o,
  output logic                   memory_0_enable_o,
  output logic                   memory_1_enable_o,
  output logic [ADDR_WIDTH-1:0]  memory_address_o
);

  localparam int HALF = half_period(SYSTEM_FREQUENCY, SAMPLING_FREQUENCY);

  state_t                  state_q, state_d;
  logic                    play_prev_q, record_prev_q;
  logic                    play_edge, record_edge;
  logic                    play_clip_q, play_clip_d;
  logic                    record_clip_q, record_clip_d;
  logic                    playing_q, playing_d;
  logic                    recording_q, recording_d;
  logic                    timer_en_q, timer_en_d;
  logic                    ser_en_q, ser_en_d;
  logic                    mem0_en_q, mem0_en_d;
  logic                    mem1_en_q, mem1_en_d;
  logic [ADDR_WIDTH-1:0]   address_q, address_d;
  logic                    advance;
  logic                    deser_done;
  logic [WORD_LENGTH-1:0]  deser_data;
  logic                    deser_pdm_clk;

  assign play_edge   = play_command_i & ~play_prev_q;
  assign record_edge = record_command_i & ~record_prev_q;

  // Clip selects follow the inputs only while idle, which also latches them
  // on the edge that leaves IDLE.
  always_comb begin
    state_d       = state_q;
    play_clip_d   = play_clip_q;
    record_clip_d = record_clip_q;
    case (state_q)
      IDLE: begin
        play_clip_d   = play_clip_select_i;
        record_clip_d = record_clip_select_i;
        if (record_edge)    state_d = RECORD;
        else if (play_edge) state_d = PLAY;
      end
      PLAY, RECORD: begin
        if (timer_done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    playing_d   = (state_d == PLAY);
    recording_d = (state_d == RECORD);
    timer_en_d  = (state_d == PLAY) || (state_d == RECORD);
    ser_en_d    = (state_d == PLAY);
    mem0_en_d   = ((state_d == PLAY)   && !play_clip_d) ||
                  ((state_d == RECORD) && !record_clip_d);
    mem1_en_d   = ((state_d == PLAY)   &&  play_clip_d) ||
                  ((state_d == RECORD) &&  record_clip_d);
  end

  // Clear has priority over a coincident done pulse.
  always_comb begin
    advance = ((state_q == PLAY)   && serializer_done_i) ||
              ((state_q == RECORD) && deser_done);
    if ((state_q == IDLE) || timer_done_i) begin
      address_d = '0;
    end else if (advance) begin
      address_d = (address_q == ADDR_MAX) ? '0 : address_q + 1'b1;
    end else begin
      address_d = address_q;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q       <= IDLE;
      play_prev_q   <= 1'b0;
      record_prev_q <= 1'b0;
      play_clip_q   <= 1'b0;
      record_clip_q <= 1'b0;
      playing_q     <= 1'b0;
      recording_q   <= 1'b0;
      timer_en_q    <= 1'b0;
      ser_en_q      <= 1'b0;
      mem0_en_q     <= 1'b0;
      mem1_en_q     <= 1'b0;
      address_q     <= '0;
    end else begin
      state_q       <= state_d;
      play_prev_q   <= play_command_i;
      record_prev_q <= record_command_i;
      play_clip_q   <= play_clip_d;
      record_clip_q <= record_clip_d;
      playing_q     <= playing_d;
      recording_q   <= recording_d;
      timer_en_q    <= timer_en_d;
      ser_en_q      <= ser_en_d;
      mem0_en_q     <= mem0_en_d;
      mem1_en_q     <= mem1_en_d;
      address_q     <= address_d;
    end
  end

  pdm_deserializer #(
    .WORD_LENGTH (WORD_LENGTH),
    .HALF        (HALF)
  ) u_deser (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .enable_i   (recording_q),
    .pdm_data_i (pdm_data_i),
    .pdm_clk_o  (deser_pdm_clk),
    .done_o     (deser_done),
    .data_o     (deser_data)
  );

  assign pdm_clk_o           = deser_pdm_clk;
  assign deserializer_done_o = deser_done;
  assign deserializer_data_o = deser_data;
  // The write happens only in the cycle a completed word is presented.
  assign memory_rw_o         = recording_q & deser_done;
  assign playing_o           = playing_q;
  assign recording_o         = recording_q;
  assign timer_enable_o      = timer_en_q;
  assign serializer_enable_o = ser_en_q;
  assign memory_0_enable_o   = mem0_en_q;
  assign memory_1_enable_o   = mem1_en_q;
  assign memory_address_o    = address_q;
  assign play_clip_o         = {3'b000, play_clip_q};
  assign record_clip_o       = {3'b000, record_clip_q};

endmodule

// File: tb/tb_clip_record_play_core.sv
// Directed bench for clip_record_play_core: reset, play addressing and wrap,
// PDM record timing/data, command priority and reset abort.
`timescale 1ns/1ps

module tb_clip_record_play_core;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        play_command_i, record_command_i;
  logic        play_clip_select_i, record_clip_select_i;
  logic        timer_done_i, serializer_done_i;
  logic        pdm_data_i;
  logic        pdm_clk_o, playing_o, recording_o;
  logic [3:0]  play_clip_o, record_clip_o;
  logic        timer_enable_o, serializer_enable_o;
  logic        deserializer_done_o;
  logic [15:0] deserializer_data_o;
  logic        memory_rw_o, memory_0_enable_o, memory_1_enable_o;
  logic [16:0] memory_address_o;

  logic        pdm_sync = 1'b0;
  logic        pdm_toggle;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  // Microphone model: data flips on every falling PDM clock, so successive
  // rising-edge samples alternate 0,1,0,1... after a resync.
  always @(negedge pdm_clk_o or posedge pdm_sync) begin
    if (pdm_sync) pdm_toggle <= 1'b0;
    else          pdm_toggle <= ~pdm_toggle;
  end
  assign pdm_data_i = pdm_toggle;

  clip_record_play_core dut (
    .clock_i              (clk),
    .reset_i              (reset_i),
    .play_command_i       (play_command_i),
    .record_command_i     (record_command_i),
    .play_clip_select_i   (play_clip_select_i),
    .record_clip_select_i (record_clip_select_i),
    .timer_done_i         (timer_done_i),
    .serializer_done_i    (serializer_done_i),
    .pdm_data_i           (pdm_data_i),
    .pdm_clk_o            (pdm_clk_o),
    .playing_o            (playing_o),
    .recording_o          (recording_o),
    .play_clip_o          (play_clip_o),
    .record_clip_o        (record_clip_o),
    .timer_enable_o       (timer_enable_o),
    .serializer_enable_o  (serializer_enable_o),
    .deserializer_done_o  (deserializer_done_o),
    .deserializer_data_o  (deserializer_data_o),
    .memory_rw_o          (memory_rw_o),
    .memory_0_enable_o    (memory_0_enable_o),
    .memory_1_enable_o    (memory_1_enable_o),
    .memory_address_o     (memory_address_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resync_pdm();
    pdm_sync = 1'b1;
    #1;
    pdm_sync = 1'b0;
  endtask

  initial begin
    reset_i = 1'b0;
    play_command_i = 1'b0;
    record_command_i = 1'b0;
    play_clip_select_i = 1'b0;
    record_clip_select_i = 1'b0;
    timer_done_i = 1'b0;
    serializer_done_i = 1'b0;
    resync_pdm();
    repeat (3) tick();

    $display("step reset: outputs idle");
    check("rst_playing", 32'(playing_o), 0);
    check("rst_recording", 32'(recording_o), 0);
    check("rst_pdm_clk", 32'(pdm_clk_o), 0);
    check("rst_timer_en", 32'(timer_enable_o), 0);
    check("rst_ser_en", 32'(serializer_enable_o), 0);
    check("rst_done", 32'(deserializer_done_o), 0);
    check("rst_data", 32'(deserializer_data_o), 0);
    check("rst_rw", 32'(memory_rw_o), 0);
    check("rst_mem0", 32'(memory_0_enable_o), 0);
    check("rst_mem1", 32'(memory_1_enable_o), 0);
    check("rst_addr", 32'(memory_address_o), 0);
    check("rst_play_clip", 32'(play_clip_o), 0);
    check("rst_rec_clip", 32'(record_clip_o), 0);

    reset_i = 1'b1;
    tick();

    $display("step play: clip 1 play edge");
    play_clip_select_i = 1'b1;
    play_command_i = 1'b1;
    tick();
    check("play_playing", 32'(playing_o), 1);
    check("play_mem1", 32'(memory_1_enable_o), 1);
    check("play_mem0", 32'(memory_0_enable_o), 0);
    check("play_clip", 32'(play_clip_o), 1);
    check("play_rw", 32'(memory_rw_o), 0);
    check("play_ser_en", 32'(serializer_enable_o), 1);
    check("play_timer_en", 32'(timer_enable_o), 1);
    check("play_recording", 32'(recording_o), 0);
    play_clip_select_i = 1'b0;
    tick();
    check("play_clip_latched", 32'(play_clip_o), 1);
    check("play_mem1_held", 32'(memory_1_enable_o), 1);

    $display("step play: three serializer_done pulses");
    for (int i = 0; i < 3; i++) begin
      serializer_done_i = 1'b1;
      tick();
      serializer_done_i = 1'b0;
      tick();
    end
    check("play_addr3", 32'(memory_address_o), 3);

    $display("step play: address wrap from 0x1FFFE");
    force dut.address_q = 17'h1FFFE;
    #1;
    release dut.address_q;
    serializer_done_i = 1'b1;
    tick();
    check("wrap_max", 32'(memory_address_o), 32'h1FFFF);
    tick();
    check("wrap_zero", 32'(memory_address_o), 0);
    tick();
    check("wrap_one", 32'(memory_address_o), 1);

    $display("step play: timer_done coincident with serializer_done");
    timer_done_i = 1'b1;
    tick();
    timer_done_i = 1'b0;
    serializer_done_i = 1'b0;
    play_command_i = 1'b0;
    check("pend_playing", 32'(playing_o), 0);
    check("pend_addr", 32'(memory_address_o), 0);
    check("pend_mem1", 32'(memory_1_enable_o), 0);
    check("pend_timer_en", 32'(timer_enable_o), 0);
    play_clip_select_i = 1'b1;
    tick();
    check("idle_track_clip", 32'(play_clip_o), 1);
    serializer_done_i = 1'b1;
    tick();
    serializer_done_i = 1'b0;
    check("idle_addr_held", 32'(memory_address_o), 0);

    $display("step record: clip 0, two words");
    record_clip_select_i = 1'b0;
    resync_pdm();
    record_command_i = 1'b1;
    tick();
    check("rec_recording", 32'(recording_o), 1);
    check("rec_mem0", 32'(memory_0_enable_o), 1);
    check("rec_mem1", 32'(memory_1_enable_o), 0);
    check("rec_ser_en", 32'(serializer_enable_o), 0);
    check("rec_timer_en", 32'(timer_enable_o), 1);
    check("rec_pdm_clk0", 32'(pdm_clk_o), 0);
    for (int k = 1; k <= 320; k++) begin
      tick();
      check("rec_pdm_clk", 32'(pdm_clk_o), 32'((k / 5) % 2));
      check("rec_done", 32'(deserializer_done_o), 32'((k == 160) || (k == 320)));
      check("rec_rw", 32'(memory_rw_o), 32'((k == 160) || (k == 320)));
      if (k == 160) begin
        $display("word 0 done at cycle %0d", k);
        check("rec_w0_data", 32'(deserializer_data_o), 32'h5555);
        check("rec_w0_addr", 32'(memory_address_o), 0);
      end
      if (k == 161) check("rec_addr1", 32'(memory_address_o), 1);
      if (k == 320) begin
        $display("word 1 done at cycle %0d", k);
        check("rec_w1_data", 32'(deserializer_data_o), 32'h5555);
        check("rec_w1_addr", 32'(memory_address_o), 1);
      end
    end
    tick();
    check("rec_addr2", 32'(memory_address_o), 2);
    timer_done_i = 1'b1;
    record_command_i = 1'b0;
    tick();
    timer_done_i = 1'b0;
    check("rend_recording", 32'(recording_o), 0);
    check("rend_pdm_clk", 32'(pdm_clk_o), 0);
    check("rend_addr", 32'(memory_address_o), 0);
    check("rend_mem0", 32'(memory_0_enable_o), 0);

    $display("step both edges: record wins, play ignored");
    record_clip_select_i = 1'b1;
    play_clip_select_i = 1'b0;
    play_command_i = 1'b1;
    record_command_i = 1'b1;
    tick();
    check("both_recording", 32'(recording_o), 1);
    check("both_playing", 32'(playing_o), 0);
    check("both_mem1", 32'(memory_1_enable_o), 1);
    check("both_mem0", 32'(memory_0_enable_o), 0);
    check("both_rec_clip", 32'(record_clip_o), 1);
    play_command_i = 1'b0;
    record_clip_select_i = 1'b0;
    tick();
    play_command_i = 1'b1;
    tick();
    check("ign_recording", 32'(recording_o), 1);
    check("ign_playing", 32'(playing_o), 0);
    check("ign_rec_clip", 32'(record_clip_o), 1);
    timer_done_i = 1'b1;
    play_command_i = 1'b0;
    record_command_i = 1'b0;
    tick();
    timer_done_i = 1'b0;
    check("both_end_recording", 32'(recording_o), 0);

    $display("step reset abort mid-record");
    resync_pdm();
    record_command_i = 1'b1;
    tick();
    for (int k = 1; k <= 87; k++) tick();
    check("abort_pdm_before", 32'(pdm_clk_o), 1);
    #2;
    reset_i = 1'b0;
    record_command_i = 1'b0;
    #1;
    check("abort_pdm_clk", 32'(pdm_clk_o), 0);
    check("abort_recording", 32'(recording_o), 0);
    check("abort_mem0", 32'(memory_0_enable_o), 0);
    check("abort_rw", 32'(memory_rw_o), 0);
    check("abort_data", 32'(deserializer_data_o), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("abort_done", 32'(deserializer_done_o), 0);
    end
    reset_i = 1'b1;
    tick();
    check("abort_idle", 32'(recording_o), 0);

    $display("step record after abort: full first word");
    resync_pdm();
    record_command_i = 1'b1;
    tick();
    check("re_recording", 32'(recording_o), 1);
    for (int k = 1; k <= 160; k++) begin
      tick();
      check("re_done", 32'(deserializer_done_o), 32'(k == 160));
      if (k == 160) begin
        $display("word 0 done at cycle %0d", k);
        check("re_data", 32'(deserializer_data_o), 32'h5555);
        check("re_rw", 32'(memory_rw_o), 1);
        check("re_addr", 32'(memory_address_o), 0);
      end
    end
    timer_done_i = 1'b1;
    record_command_i = 1'b0;
    tick();
    timer_done_i = 1'b0;
    check("re_end_recording", 32'(recording_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
